// File: rtl/lane_word2byte_tx.sv
// ---------------------------------------------------------------------------
// lane_word2byte_tx
//   Per-lane word-to-byte serializer for the TX path. It accepts one lane
//   word through a valid/ready handshake and emits one byte per clk_4f,
//   sending the most significant byte first. When no word is available it
//   fills the byte slot with IDLE_SYM, so the line coder never stalls. Each
//   time the lane is activated, it sends a SYNC_LEN-symbol training
//   preamble before any data.
//
// Ports
//   clk_4f     : byte-rate clock (4x word rate)
//   reset      : synchronous, active-high
//   active     : lane enable; 0 = lane quiescent
//   valid_in   : data_in holds a word
//   data_in    : lane word
//   ready_out  : block can take a word this cycle (decoded from registers)
//   data_out   : byte to line coder (registered)
//   valid_out  : data_out is a data byte (registered)
//   k_out      : data_out is the IDLE_SYM control symbol (registered)
//   words_sent : count of fully transmitted words, wraps (registered)
// ---------------------------------------------------------------------------
module lane_word2byte_tx #(
  parameter int                 WORD_W   = 32,
  parameter int                 BYTE_W   = 8,
  parameter logic [BYTE_W-1:0]  IDLE_SYM = 8'hBC,
  parameter int                 SYNC_LEN = 4
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              active,
  input  logic              valid_in,
  input  logic [WORD_W-1:0] data_in,
  output logic              ready_out,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              k_out,
  output logic [15:0]       words_sent
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [3:0]          sync_cnt_r, sync_cnt_nxt_s;
  logic [WORD_W-1:0]   hold_r, hold_nxt_s;
  logic                hold_full_r, hold_full_nxt_s;
  logic [WORD_W-1:0]   shift_r, shift_nxt_s;
  logic [1:0]          byte_cnt_r, byte_cnt_nxt_s;
  logic [BYTE_W-1:0]   data_nxt_s;
  logic                valid_nxt_s;
  logic                k_nxt_s;
  logic [15:0]         words_nxt_s;
  logic                accept_s;
  logic [BYTE_W-1:0]   shift_byte_s;

  // Handshake decode: only registered state feeds ready_out.
  assign ready_out = (state_r != ST_OFF) && !hold_full_r;
  assign accept_s  = valid_in && ready_out;

  // Byte byte_cnt_r of the shifter, byte 0 being the top byte.
  assign shift_byte_s = shift_r[WORD_W-1-(int'(byte_cnt_r)*BYTE_W) -: BYTE_W];

  // Next-state, storage and output decode for the lane FSM.
  always_comb begin
    state_nxt_s     = state_r;
    sync_cnt_nxt_s  = sync_cnt_r;
    hold_nxt_s      = hold_r;
    hold_full_nxt_s = hold_full_r;
    shift_nxt_s     = shift_r;
    byte_cnt_nxt_s  = byte_cnt_r;
    data_nxt_s      = {BYTE_W{1'b0}};
    valid_nxt_s     = 1'b0;
    k_nxt_s         = 1'b0;
    words_nxt_s     = words_sent;

    if (!active) begin
      // Lane drop: discard everything in flight, the count is left alone.
      state_nxt_s     = ST_OFF;
      sync_cnt_nxt_s  = 4'd0;
      hold_full_nxt_s = 1'b0;
      byte_cnt_nxt_s  = 2'd0;
    end else begin
      case (state_r)
        ST_OFF: begin
          state_nxt_s    = ST_SYNC;
          sync_cnt_nxt_s = 4'd0;
        end

        ST_SYNC: begin
          data_nxt_s = IDLE_SYM;
          k_nxt_s    = 1'b1;
          if (accept_s) begin
            hold_nxt_s      = data_in;
            hold_full_nxt_s = 1'b1;
          end else begin
            hold_nxt_s = hold_r;
          end
          if (sync_cnt_r == 4'(SYNC_LEN - 1)) begin
            state_nxt_s = ST_RUN;
          end else begin
            sync_cnt_nxt_s = sync_cnt_r + 4'd1;
          end
        end

        ST_RUN: begin
          if (accept_s) begin
            hold_nxt_s      = data_in;
            hold_full_nxt_s = 1'b1;
          end else begin
            hold_nxt_s = hold_r;
          end

          if (byte_cnt_r != 2'd0) begin
            data_nxt_s     = shift_byte_s;
            valid_nxt_s    = 1'b1;
            byte_cnt_nxt_s = byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              words_nxt_s = words_sent + 16'd1;
            end else begin
              words_nxt_s = words_sent;
            end
          end else if (hold_full_r) begin
            // Byte 0 leaves straight from hold, so the shifter starts at 1.
            data_nxt_s      = hold_r[WORD_W-1 -: BYTE_W];
            valid_nxt_s     = 1'b1;
            shift_nxt_s     = hold_r;
            byte_cnt_nxt_s  = 2'd1;
            hold_full_nxt_s = accept_s;
          end else begin
            data_nxt_s = IDLE_SYM;
            k_nxt_s    = 1'b1;
          end
        end

        default: begin
          state_nxt_s     = ST_OFF;
          hold_full_nxt_s = 1'b0;
          byte_cnt_nxt_s  = 2'd0;
        end
      endcase
    end
  end

  // State, storage and registered outputs; reset wins over everything.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_r     <= ST_OFF;
      sync_cnt_r  <= 4'd0;
      hold_r      <= {WORD_W{1'b0}};
      hold_full_r <= 1'b0;
      shift_r     <= {WORD_W{1'b0}};
      byte_cnt_r  <= 2'd0;
      data_out    <= {BYTE_W{1'b0}};
      valid_out   <= 1'b0;
      k_out       <= 1'b0;
      words_sent  <= 16'd0;
    end else begin
      state_r     <= state_nxt_s;
      sync_cnt_r  <= sync_cnt_nxt_s;
      hold_r      <= hold_nxt_s;
      hold_full_r <= hold_full_nxt_s;
      shift_r     <= shift_nxt_s;
      byte_cnt_r  <= byte_cnt_nxt_s;
      data_out    <= data_nxt_s;
      valid_out   <= valid_nxt_s;
      k_out       <= k_nxt_s;
      words_sent  <= words_nxt_s;
    end
  end

endmodule

// File: tb/tb_lane_word2byte_tx.sv
// ---------------------------------------------------------------------------
// tb_lane_word2byte_tx
//   Bench for lane_word2byte_tx. A queue-based reference model tracks the
//   lane phase, the pending word and the bytes still to go. Every cycle the
//   bench compares ready_out, data_out, valid_out, k_out and words_sent
//   against that model. Directed scenarios come first, followed by a
//   randomized run.
// ---------------------------------------------------------------------------
module tb_lane_word2byte_tx;

  localparam int SYNC_LEN = 4;
  localparam logic [7:0] IDLE = 8'hBC;

  logic        clk_4f;
  logic        reset;
  logic        active;
  logic        valid_in;
  logic [31:0] data_in;
  logic        ready_out;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        k_out;
  logic [15:0] words_sent;

  lane_word2byte_tx #(
    .WORD_W  (32),
    .BYTE_W  (8),
    .IDLE_SYM(8'hBC),
    .SYNC_LEN(SYNC_LEN)
  ) dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .active    (active),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .k_out     (k_out),
    .words_sent(words_sent)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_off;
  int          m_sync_left;
  logic [31:0] m_hold_q[$];
  logic [7:0]  m_bytes_q[$];
  logic [15:0] m_words;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_k;

  // Producer queue: words waiting to be offered on valid_in/data_in
  logic [31:0] tx_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_hold_q.delete();
    m_bytes_q.delete();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_k     = 1'b0;
  endtask

  task automatic model_step(input logic acc);
    logic [31:0] w;
    if (reset) begin
      m_off = 1'b1;
      model_clear();
      m_words = 16'd0;
    end else if (!active) begin
      m_off = 1'b1;
      model_clear();
    end else if (m_off) begin
      m_off       = 1'b0;
      m_sync_left = SYNC_LEN;
      model_clear();
    end else begin
      m_data  = IDLE;
      m_valid = 1'b0;
      m_k     = 1'b1;
      if (m_sync_left > 0) begin
        m_sync_left--;
      end else if (m_bytes_q.size() > 0) begin
        m_data  = m_bytes_q.pop_front();
        m_valid = 1'b1;
        m_k     = 1'b0;
        if (m_bytes_q.size() == 0) m_words = m_words + 16'd1;
      end else if (m_hold_q.size() > 0) begin
        w       = m_hold_q.pop_front();
        m_data  = w[31:24];
        m_valid = 1'b1;
        m_k     = 1'b0;
        m_bytes_q.push_back(w[23:16]);
        m_bytes_q.push_back(w[15:8]);
        m_bytes_q.push_back(w[7:0]);
      end
      if (acc) m_hold_q.push_back(data_in);
    end
  endtask

  // One clock: present producer inputs, check ready, clock, check outputs.
  task automatic cycle();
    logic m_ready;
    logic acc;
    valid_in = (tx_q.size() > 0);
    data_in  = (tx_q.size() > 0) ? tx_q[0] : 32'h0;
    m_ready  = !m_off && (m_hold_q.size() == 0);
    check_val("ready_out", {31'd0, ready_out}, {31'd0, m_ready});
    acc = valid_in && m_ready && active && !reset;
    @(posedge clk_4f);
    model_step(acc);
    if (acc) void'(tx_q.pop_front());
    #1;
    check_val("data_out",   {24'd0, data_out},  {24'd0, m_data});
    check_val("valid_out",  {31'd0, valid_out}, {31'd0, m_valid});
    check_val("k_out",      {31'd0, k_out},     {31'd0, m_k});
    check_val("words_sent", {16'd0, words_sent}, {16'd0, m_words});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int guard;
    logic [15:0] words_before;

    reset    = 1'b1;
    active   = 1'b1;
    valid_in = 1'b0;
    data_in  = 32'h0;
    m_off    = 1'b1;
    m_sync_left = 0;
    m_words  = 16'd0;
    model_clear();

    // Flush X out of the registers before the first compare.
    @(posedge clk_4f);
    #1;

    // 1: reset held with active=1
    run(3);
    check_val("t1_ready", {31'd0, ready_out}, 32'd0);

    // 2: preamble then idle fill
    reset = 1'b0;
    run(1 + SYNC_LEN + 3);
    check_val("t2_idle_k", {31'd0, k_out}, 32'd1);
    check_val("t2_idle_sym", {24'd0, data_out}, {24'd0, IDLE});

    // 3: two back-to-back words
    tx_q.push_back(32'hFFFFEEEE);
    tx_q.push_back(32'h12345678);
    run(12);
    check_val("t3_words", {16'd0, words_sent}, 32'd2);

    // 4: single word then idle
    tx_q.push_back(32'hAAAA1234);
    run(8);
    check_val("t4_words", {16'd0, words_sent}, 32'd3);
    check_val("t4_idle_k", {31'd0, k_out}, 32'd1);

    // 5: drop active after byte1, then re-activate
    tx_q.push_back(32'hCCEEEEEE);
    guard = 0;
    while (m_bytes_q.size() != 2 && guard < 20) begin
      cycle();
      guard++;
    end
    check_val("t5_reach_byte1", {31'd0, (guard < 20)}, 32'd1);
    words_before = words_sent;
    active = 1'b0;
    run(1);
    check_val("t5_off_valid", {31'd0, valid_out}, 32'd0);
    check_val("t5_off_data", {24'd0, data_out}, 32'd0);
    check_val("t5_words_hold", {16'd0, words_sent}, {16'd0, words_before});
    run(2);
    active = 1'b1;
    tx_q.push_back(32'h5A5AC3C3);
    run(1 + SYNC_LEN + 8);

    // 6: valid held while hold is full, word taken exactly once
    tx_q.push_back(32'h11223344);
    tx_q.push_back(32'hBBBBAAAA);
    run(14);
    check_val("t6_words", {16'd0, words_sent}, {16'd0, words_before + 16'd3});

    // Randomized traffic with lane drops and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (tx_q.size() == 0 && $urandom_range(0, 2) != 0) tx_q.push_back($urandom);
      if (active && $urandom_range(0, 149) == 0) begin
        active = 1'b0;
      end else if (!active && $urandom_range(0, 5) == 0) begin
        active = 1'b1;
      end
      reset = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset  = 1'b0;
    active = 1'b1;
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
